// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_pkg
//  Description : Shared types and constants for the CPU I/O request controller:
//                controller states, display-mode encodings, 7-seg patterns and
//                the double-dabble digit adjust helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONV_OUT = 2'd1,
        ST_WAIT_IN  = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    // Display-mode encodings presented to the 7-seg decoder
    localparam logic [1:0] c_DISP_BLANK  = 2'd0;
    localparam logic [1:0] c_DISP_NUMBER = 2'd1;
    localparam logic [1:0] c_DISP_DASHES = 2'd2;
    localparam logic [1:0] c_DISP_HALT   = 2'd3;

    // Internal BCD width of the converter (enough for a full 32-bit value)
    localparam int c_BCD_DIGITS = 10;
    localparam int c_BCD_W      = 4 * c_BCD_DIGITS;

    // 7-seg patterns, bit order {g,f,e,d,c,b,a}, active-high segments
    localparam logic [6:0] c_SEG_BLANK = 7'h00;
    localparam logic [6:0] c_SEG_DASH  = 7'h40;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = c_SEG_BLANK;
        endcase
        return r;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift
    function automatic logic [c_BCD_W-1:0] bcd_adjust(input logic [c_BCD_W-1:0] b);
        logic [c_BCD_W-1:0] r;
        for (int i = 0; i < c_BCD_DIGITS; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter. One input
//                bit per cycle, MSB first. The first bit is consumed in the
//                start cycle, so done pulses exactly DATA_W cycles after start.
//                A start while busy abandons the current run and reloads.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import io_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   din,
    output logic                busy,
    output logic                done,
    output logic [c_BCD_W-1:0]  bcd
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0]  r_shift;
    logic [c_BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [c_BCD_W-1:0] w_adj;

    assign w_adj = bcd_adjust(r_bcd);

    // Load on start, then adjust-and-shift one bit per cycle until all bits are in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bcd   <= {{(c_BCD_W-1){1'b0}}, din[DATA_W-1]};
                r_shift <= {din[DATA_W-2:0], 1'b0};
                r_cnt   <= CNT_W'(1);
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_bcd   <= (w_adj << 1) | {{(c_BCD_W-1){1'b0}}, r_shift[DATA_W-1]};
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                r_cnt   <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(DATA_W-1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// ============================================================================
//  Module      : debounce
//  Description : Two-flop synchroniser, stability counter and rising-edge
//                detector for the raw confirm button. The counter restarts on
//                every change of the synchronised level; the debounced level
//                follows once the input has been stable long enough.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_q;

    // Synchronise, time stability of the synced level, and register the accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_level_q   <= 1'b0;
        end else begin
            r_sync1     <= i_btn;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_level_q   <= r_level;
            if (r_sync2 != r_sync_prev) begin
                r_cnt <= '0;
            end else if (r_sync2 != r_level) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES-1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_rise = r_level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/io_request_controller.sv
`default_nettype none
// ============================================================================
//  Module      : io_request_controller
//  Description : Sequences CPU output/input instructions against the board
//                display and switches. Output requests convert a value to
//                decimal and acknowledge; input requests show the live switch
//                value until a debounced confirm press captures it.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_request_controller
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              out_req,
    input  logic [DATA_W-1:0] out_data,
    input  logic              in_req,
    input  logic [15:0]       SW,
    input  logic              confirm_btn,
    output logic              out_ack,
    output logic              in_ack,
    output logic [DATA_W-1:0] in_data,
    output logic              stall,
    output logic [31:0]       digits,
    output logic [1:0]        disp_mode
);

    state_t             r_state;
    state_t             w_next_state;

    logic               r_out_ack;
    logic               r_in_ack;
    logic [DATA_W-1:0]  r_in_data;
    logic [31:0]        r_digits;
    logic [1:0]         r_disp_mode;

    logic               w_out_pend;
    logic               w_in_pend;
    logic               w_stall;
    logic               w_conv_start;
    logic [DATA_W-1:0]  w_conv_din;
    logic               w_conv_busy;
    logic               w_conv_done;
    logic [c_BCD_W-1:0] w_conv_bcd;
    logic               w_confirm;
    logic [DATA_W-1:0]  w_sw_word;

    assign w_sw_word = {{(DATA_W-16){1'b0}}, SW};

    // Requests are still held high during their own ack cycle; masking them there
    // keeps the same request from being served twice.
    assign w_out_pend = out_req & ~(r_out_ack | r_in_ack);
    assign w_in_pend  = in_req  & ~(r_out_ack | r_in_ack);

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (reset),
        .start (w_conv_start),
        .din   (w_conv_din),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_conv_bcd)
    );

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (reset),
        .i_btn  (confirm_btn),
        .o_rise (w_confirm)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: halt overrides everything, output beats input in IDLE
    always_comb begin
        w_next_state = r_state;
        if (halt) begin
            w_next_state = ST_HALTED;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_out_pend) begin
                        w_next_state = ST_CONV_OUT;
                    end else if (w_in_pend) begin
                        w_next_state = ST_WAIT_IN;
                    end
                end
                ST_CONV_OUT: if (w_conv_done) w_next_state = ST_IDLE;
                ST_WAIT_IN:  if (w_confirm)   w_next_state = ST_IDLE;
                ST_HALTED:   w_next_state = ST_HALTED;
                default:     w_next_state = ST_IDLE;
            endcase
        end
    end

    // Output logic: stall, converter start and converter operand selection
    always_comb begin
        w_stall      = 1'b0;
        w_conv_start = 1'b0;
        w_conv_din   = w_sw_word;
        case (r_state)
            ST_IDLE: begin
                w_stall = (w_out_pend | w_in_pend) & ~halt;
                if (w_out_pend && !halt) begin
                    w_conv_start = 1'b1;
                    w_conv_din   = out_data;
                end
            end
            ST_CONV_OUT: w_stall = 1'b1;
            ST_WAIT_IN: begin
                w_stall      = 1'b1;
                // Free-run on the switches, restarting the cycle after each done
                w_conv_start = ~w_conv_busy & ~w_conv_done & ~halt;
            end
            default: ;
        endcase
    end

    // Capture registers: display state, input data and ack pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_ack   <= 1'b0;
            r_in_ack    <= 1'b0;
            r_in_data   <= '0;
            r_digits    <= '0;
            r_disp_mode <= c_DISP_BLANK;
        end else begin
            r_out_ack <= 1'b0;
            r_in_ack  <= 1'b0;
            if (halt) begin
                r_disp_mode <= c_DISP_HALT;
            end else begin
                case (r_state)
                    ST_CONV_OUT: begin
                        if (w_conv_done) begin
                            r_digits    <= w_conv_bcd[31:0];
                            r_disp_mode <= c_DISP_NUMBER;
                            r_out_ack   <= 1'b1;
                        end
                    end
                    ST_WAIT_IN: begin
                        if (w_confirm) begin
                            r_in_data <= w_sw_word;
                            r_in_ack  <= 1'b1;
                        end else if (w_conv_done) begin
                            r_digits    <= w_conv_bcd[31:0];
                            r_disp_mode <= (w_conv_bcd == '0) ? c_DISP_DASHES : c_DISP_NUMBER;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_ack   = r_out_ack;
    assign in_ack    = r_in_ack;
    assign in_data   = r_in_data;
    assign stall     = w_stall;
    assign digits    = r_digits;
    assign disp_mode = r_disp_mode;

endmodule
`default_nettype wire

// File: tb/tb_io_request_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_request_controller
//  Description : Scoreboard bench for io_request_controller. Expected ack
//                results are queued when a request is driven and compared by a
//                monitor when the matching ack pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_request_controller;

    localparam int c_DEB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        out_req;
    logic [31:0] out_data;
    logic        in_req;
    logic [15:0] SW;
    logic        confirm_btn;
    logic        out_ack;
    logic        in_ack;
    logic [31:0] in_data;
    logic        stall;
    logic [31:0] digits;
    logic [1:0]  disp_mode;

    always #5 clk = ~clk;

    io_request_controller #(
        .DEBOUNCE_CYCLES (c_DEB),
        .DATA_W          (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .out_req     (out_req),
        .out_data    (out_data),
        .in_req      (in_req),
        .SW          (SW),
        .confirm_btn (confirm_btn),
        .out_ack     (out_ack),
        .in_ack      (in_ack),
        .in_data     (in_data),
        .stall       (stall),
        .digits      (digits),
        .disp_mode   (disp_mode)
    );

    typedef struct {
        bit          is_in;
        logic [31:0] val;
        logic [1:0]  mode;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   n_out_acks = 0;
    int   n_in_acks  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: value mod 10^8 as eight BCD digits
    function automatic logic [31:0] dec8(input longint unsigned v);
        logic [31:0]     r;
        longint unsigned x;
        x = v % 64'd100000000;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic push_exp(input bit is_in, input logic [31:0] val, input logic [1:0] mode);
        exp_t e;
        e.is_in = is_in;
        e.val   = val;
        e.mode  = mode;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every ack pulse must match the oldest queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (out_ack === 1'b1 || in_ack === 1'b1) begin
            if (out_ack === 1'b1) n_out_acks++;
            if (in_ack === 1'b1)  n_in_acks++;
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", {30'b0, in_ack, out_ack}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ack_kind", {30'b0, in_ack, out_ack}, e.is_in ? 32'd2 : 32'd1);
                if (e.is_in) begin
                    chk("sb_in_data", in_data, e.val);
                end else begin
                    chk("sb_digits", digits, e.val);
                    chk("sb_disp_mode", {30'b0, disp_mode}, {30'b0, e.mode});
                end
            end
        end
    end

    task automatic wait_ack(input bit want_in, input int limit, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if ((want_in ? in_ack : out_ack) === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic wait_disp(input logic [1:0] m, input logic [31:0] d, input int limit,
                             output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (disp_mode === m && digits === d) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_ack"}, {31'b0, out_ack}, 32'd0);
        chk({tag, "_in_ack"},  {31'b0, in_ack},  32'd0);
        chk({tag, "_in_data"}, in_data, 32'd0);
        chk({tag, "_digits"},  digits, 32'd0);
        chk({tag, "_disp"},    {30'b0, disp_mode}, 32'd0);
        chk({tag, "_stall"},   {31'b0, stall}, 32'd0);
    endtask

    // Output request issued at a falling edge; ack expected 33 cycles later
    task automatic do_out(input logic [31:0] v, input bit with_in);
        int k;
        @(negedge clk);
        out_data = v;
        out_req  = 1'b1;
        in_req   = with_in;
        push_exp(1'b0, dec8(64'(v)), 2'd1);
        #1 chk("stall_on_req", {31'b0, stall}, 32'd1);
        wait_ack(1'b0, 60, k);
        chk("out_ack_latency", k, 32'd33);
        if (!with_in) chk("stall_in_ack_cycle", {31'b0, stall}, 32'd0);
        if (with_in) chk("in_ack_not_first", {31'b0, in_ack}, 32'd0);
        out_req = 1'b0;
        @(negedge clk);
        chk("out_ack_single_pulse", {31'b0, out_ack}, 32'd0);
    endtask

    task automatic press_confirm(input logic [31:0] exp_val);
        int k;
        push_exp(1'b1, exp_val, 2'd0);
        confirm_btn = 1'b1;
        wait_ack(1'b1, 40, k);
        chk("confirm_latency_ok", {31'b0, (k >= c_DEB && k <= c_DEB + 6)}, 32'd1);
        in_req = 1'b0;
        repeat (4) @(negedge clk);
        confirm_btn = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        int acks0;
        reset       = 1'b1;
        halt        = 1'b0;
        out_req     = 1'b0;
        in_req      = 1'b0;
        out_data    = '0;
        SW          = '0;
        confirm_btn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // 1: plain output request
        do_out(32'd12345678, 1'b0);
        chk("t1_digits", digits, 32'h12345678);
        chk("t1_disp", {30'b0, disp_mode}, 32'd1);

        // 2: full-scale value, shown mod 10^8
        do_out(32'hFFFFFFFF, 1'b0);
        chk("t2_digits", digits, 32'h94967295);

        // 3: input request, dashes for zero, then a live number, then confirm
        @(negedge clk);
        SW     = 16'd0;
        in_req = 1'b1;
        wait_disp(2'd2, 32'd0, 80, k);
        chk("t3_dashes_seen", {31'b0, (k > 0)}, 32'd1);
        SW = 16'd65535;
        wait_disp(2'd1, 32'h00065535, 80, k);
        chk("t3_number_seen", {31'b0, (k > 0)}, 32'd1);
        press_confirm(32'h0000FFFF);
        chk("t3_digits_kept", digits, 32'h00065535);
        chk("t3_idle_no_stall", {31'b0, stall}, 32'd0);

        // 4a: bounce shorter than the debounce window never confirms
        @(negedge clk);
        SW     = 16'd5;
        in_req = 1'b1;
        repeat (40) @(negedge clk);
        acks0 = n_in_acks;
        for (int r = 0; r < 4; r++) begin
            confirm_btn = 1'b1;
            repeat (3) @(negedge clk);
            confirm_btn = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("t4_bounce_no_ack", n_in_acks - acks0, 32'd0);
        chk("t4_bounce_stalled", {31'b0, stall}, 32'd1);
        press_confirm(32'd5);

        // 4b: button already held on entry needs release and re-press
        @(negedge clk);
        confirm_btn = 1'b1;
        repeat (20) @(negedge clk);
        SW     = 16'd9;
        in_req = 1'b1;
        acks0  = n_in_acks;
        repeat (30) @(negedge clk);
        chk("t4_held_no_ack", n_in_acks - acks0, 32'd0);
        confirm_btn = 1'b0;
        repeat (20) @(negedge clk);
        press_confirm(32'd9);

        // 5a: simultaneous requests, output first then input
        SW = 16'd7;
        do_out(32'd42, 1'b1);
        chk("t5_out_digits", digits, 32'h00000042);
        wait_disp(2'd1, 32'h00000007, 80, k);
        chk("t5_wait_in_entered", {31'b0, (k > 0)}, 32'd1);
        chk("t5_stall_wait_in", {31'b0, stall}, 32'd1);
        press_confirm(32'd7);

        // 5b: halt during conversion aborts without ack
        @(negedge clk);
        out_data = 32'd999;
        out_req  = 1'b1;
        repeat (10) @(negedge clk);
        halt  = 1'b1;
        acks0 = n_out_acks;
        @(negedge clk);
        chk("t5_halt_disp", {30'b0, disp_mode}, 32'd3);
        chk("t5_halt_stall", {31'b0, stall}, 32'd0);
        repeat (40) @(negedge clk);
        chk("t5_halt_no_ack", n_out_acks - acks0, 32'd0);
        halt = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_halt_sticky_disp", {30'b0, disp_mode}, 32'd3);
        chk("t5_halt_sticky_stall", {31'b0, stall}, 32'd0);
        reset   = 1'b1;
        out_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_reset_clears_halt", {30'b0, disp_mode}, 32'd0);

        // 6: reset in the middle of an input request, then normal operation
        @(negedge clk);
        SW     = 16'd123;
        in_req = 1'b1;
        wait_disp(2'd1, 32'h00000123, 80, k);
        chk("t6_number_seen", {31'b0, (k > 0)}, 32'd1);
        reset  = 1'b1;
        in_req = 1'b0;
        @(negedge clk);
        check_reset_state("t6_mid_reset");
        reset = 1'b0;
        do_out(32'd100, 1'b0);
        chk("t6_after_reset_digits", digits, 32'h00000100);
        repeat (5) @(negedge clk);
        chk("sb_queue_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
